// File: rtl/genome_feeder_if.sv
// Byte-stream and ViRAL-side signals of genome_feeder, bundled with
// slave (DUT) and master (driver) views.
interface genome_feeder_if #(
    parameter int BYTE      = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 s_valid;
    logic [BYTE-1:0]      s_data;
    logic                 s_last;
    logic                 s_ready;
    logic                 i_ready_to_rcv;
    logic                 o_base_ready;
    logic [BYTE-1:0]      o_base;
    logic                 o_done;
    logic [CNT_WIDTH-1:0] o_genome_cnt;
    logic                 o_len_err;
    logic                 o_char_err;

    modport slave (
        input  s_valid, s_data, s_last, i_ready_to_rcv,
        output s_ready, o_base_ready, o_base, o_done, o_genome_cnt, o_len_err, o_char_err
    );

    modport master (
        output s_valid, s_data, s_last, i_ready_to_rcv,
        input  s_ready, o_base_ready, o_base, o_done, o_genome_cnt, o_len_err, o_char_err
    );
endinterface

// File: rtl/genome_feeder.sv
// Buffers a framed ASCII base stream and re-emits each genome at exactly GENOME_LENGTH bases.
// Optional macro GENOME_FEEDER_NORMALIZE_EN: fold lowercase bases, replace invalid bytes by 'N'.
module genome_feeder #(
    parameter int BYTE            = 8,
    parameter int GENOME_LENGTH   = 1024,
    parameter int LOG2_FIFO_DEPTH = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic            clk,
    input  logic            rstn,
    genome_feeder_if.slave  bus
);
    localparam int                   DEPTH  = 1 << LOG2_FIFO_DEPTH;
    localparam logic [CNT_WIDTH-1:0] GLEN   = CNT_WIDTH'(GENOME_LENGTH);
    localparam logic [BYTE-1:0]      BASE_N = BYTE'(8'h4E);

    typedef enum logic [1:0] {
        ST_STREAM = 2'd0,
        ST_PAD    = 2'd1,
        ST_DONE   = 2'd2,
        ST_DROP   = 2'd3
    } state_e;

    logic [BYTE:0]            mem_q [DEPTH];
    logic [LOG2_FIFO_DEPTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                     full_s, empty_s, push_s, pop_s;
    logic [BYTE:0]            wr_entry_s, rd_entry_s;

    state_e                   state_q, state_d;
    logic [CNT_WIDTH-1:0]     base_cnt_q, base_cnt_d, cnt_inc_s;
    logic [CNT_WIDTH-1:0]     genome_cnt_q, genome_cnt_d;
    logic                     last_seen_q, last_seen_d;
    logic                     base_ready_q, base_ready_d;
    logic [BYTE-1:0]          base_q, base_d;
    logic                     done_q, done_d;
    logic                     len_err_q, len_err_d;

    // The extra pointer bit tells a full FIFO from an empty one.
    assign full_s  = (wr_ptr_q[LOG2_FIFO_DEPTH] != rd_ptr_q[LOG2_FIFO_DEPTH]) &&
                     (wr_ptr_q[LOG2_FIFO_DEPTH-1:0] == rd_ptr_q[LOG2_FIFO_DEPTH-1:0]);
    assign empty_s    = (wr_ptr_q == rd_ptr_q);
    assign push_s     = bus.s_valid && !full_s;
    assign rd_entry_s = mem_q[rd_ptr_q[LOG2_FIFO_DEPTH-1:0]];
    assign cnt_inc_s  = base_cnt_q + CNT_WIDTH'(1);
    assign wr_ptr_d   = wr_ptr_q + (LOG2_FIFO_DEPTH+1)'(push_s);
    assign rd_ptr_d   = rd_ptr_q + (LOG2_FIFO_DEPTH+1)'(pop_s);

`ifdef GENOME_FEEDER_NORMALIZE_EN
    logic [BYTE:0] wr_norm_s;
    logic          char_err_q, char_err_d;

    // Returns {invalid, normalised byte}.
    function automatic logic [BYTE:0] norm_base(input logic [BYTE-1:0] b);
        case (b)
            8'h41, 8'h43, 8'h47, 8'h54, 8'h4E: norm_base = {1'b0, b};
            8'h61, 8'h63, 8'h67, 8'h74, 8'h6E: norm_base = {1'b0, b ^ BYTE'(8'h20)};
            default:                           norm_base = {1'b1, BASE_N};
        endcase
    endfunction

    assign wr_norm_s      = norm_base(bus.s_data);
    assign wr_entry_s     = {bus.s_last, wr_norm_s[BYTE-1:0]};
    assign char_err_d     = char_err_q | (push_s & wr_norm_s[BYTE]);
    assign bus.o_char_err = char_err_q;

    // Sticky invalid-character flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            char_err_q <= 1'b0;
        end else begin
            char_err_q <= char_err_d;
        end
    end
`else
    assign wr_entry_s     = {bus.s_last, bus.s_data};
    assign bus.o_char_err = 1'b0;
`endif

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[LOG2_FIFO_DEPTH-1:0]] <= wr_entry_s;
        end
    end

    // Next-state and output decode for the pad/truncate FSM.
    always_comb begin
        state_d      = state_q;
        base_cnt_d   = base_cnt_q;
        last_seen_d  = last_seen_q;
        base_ready_d = 1'b0;
        base_d       = base_q;
        done_d       = 1'b0;
        genome_cnt_d = genome_cnt_q;
        len_err_d    = len_err_q;
        pop_s        = 1'b0;
        case (state_q)
            ST_STREAM: begin
                if (bus.i_ready_to_rcv && !empty_s) begin
                    pop_s        = 1'b1;
                    base_ready_d = 1'b1;
                    base_d       = rd_entry_s[BYTE-1:0];
                    base_cnt_d   = cnt_inc_s;
                    last_seen_d  = last_seen_q | rd_entry_s[BYTE];
                    if (cnt_inc_s == GLEN) begin
                        state_d = ST_DONE;
                    end else if (rd_entry_s[BYTE]) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_PAD: begin
                if (bus.i_ready_to_rcv) begin
                    base_ready_d = 1'b1;
                    base_d       = BASE_N;
                    base_cnt_d   = cnt_inc_s;
                    len_err_d    = 1'b1;
                    state_d      = (cnt_inc_s == GLEN) ? ST_DONE : ST_PAD;
                end else begin
                    state_d = ST_PAD;
                end
            end
            ST_DONE: begin
                if (bus.i_ready_to_rcv) begin
                    done_d       = 1'b1;
                    genome_cnt_d = genome_cnt_q + CNT_WIDTH'(1);
                    base_cnt_d   = {CNT_WIDTH{1'b0}};
                    last_seen_d  = 1'b0;
                    state_d      = last_seen_q ? ST_STREAM : ST_DROP;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DROP: begin
                // Only STREAM pops mark last_seen; the tail of a truncated genome must not.
                len_err_d = 1'b1;
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_d = rd_entry_s[BYTE] ? ST_STREAM : ST_DROP;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_STREAM;
            end
        endcase
    end

    // All control state and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= ST_STREAM;
            base_cnt_q   <= '0;
            genome_cnt_q <= '0;
            last_seen_q  <= 1'b0;
            base_ready_q <= 1'b0;
            base_q       <= '0;
            done_q       <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            base_cnt_q   <= base_cnt_d;
            genome_cnt_q <= genome_cnt_d;
            last_seen_q  <= last_seen_d;
            base_ready_q <= base_ready_d;
            base_q       <= base_d;
            done_q       <= done_d;
            len_err_q    <= len_err_d;
        end
    end

    assign bus.s_ready      = !full_s;
    assign bus.o_base_ready = base_ready_q;
    assign bus.o_base       = base_q;
    assign bus.o_done       = done_q;
    assign bus.o_genome_cnt = genome_cnt_q;
    assign bus.o_len_err    = len_err_q;
endmodule
